// File: rtl/blockram_access_ctrl_pkg.sv
// Shared definitions for the block-RAM access controller.
// Holds the byte width used for write masks and the controller FSM encoding.
// Imported by the RAM model and the controller top.
package blockram_access_ctrl_pkg;

    // Width of one write-mask lane.
    localparam int BYTE_LEN_IN_BITS = 8;

    typedef enum logic [1:0] {
        INIT      = 2'b00,
        IDLE      = 2'b01,
        READ_WAIT = 2'b10,
        RESP      = 2'b11
    } ctrl_state_t;

endpackage

// File: rtl/single_port_blockram.sv
// Single-port block RAM with byte-masked writes and a registered read port.
// Latency: read data appears on read_entry_out one edge after an access with write_en_in == 0.
// Backpressure: none; one access per cycle whenever access_en_in is high.
// Ports: clk_in, access_en_in, write_en_in (byte mask), access_set_addr_in,
//        write_entry_in, read_entry_out.
module single_port_blockram
    import blockram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     access_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] mem [NUM_SET];

    // Storage carries no reset; the controller clears it with its init sweep.
    always_ff @(posedge clk_in) begin
        if (access_en_in) begin
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (write_en_in[b]) begin
                    mem[access_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS]
                        <= write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
                end
            end
            read_entry_out <= mem[access_set_addr_in];
        end
    end

endmodule

// File: rtl/blockram_access_ctrl.sv
// Request/response front-end owning one single_port_blockram; clears all sets after reset.
// Latency: writes commit at the accept edge; read response valid two edges after acceptance.
// Backpressure: request_ack_out only in IDLE; one read outstanding, held until response_ack_in.
// Ports: clk_in/reset_in, init_done_out, request_* (valid/ack stream), response_* (valid/ack).
module blockram_access_ctrl
    import blockram_access_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_done_out,
    input  logic                                 request_valid_in,
    output logic                                 request_ack_out,
    input  logic                                 request_write_in,
    input  logic [WRITE_MASK_LEN-1:0]            request_write_mask_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,
    output logic                                 response_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,
    input  logic                                 response_ack_in
);

    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

    ctrl_state_t                          state;
    ctrl_state_t                          state_next;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     init_cnt;

    logic                                 ram_access_en;
    logic [WRITE_MASK_LEN-1:0]            ram_write_en;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     ram_addr;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_wdata;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] ram_rdata;

    single_port_blockram #(
        .SINGLE_ENTRY_SIZE_IN_BITS (SINGLE_ENTRY_SIZE_IN_BITS),
        .NUM_SET                   (NUM_SET),
        .SET_PTR_WIDTH_IN_BITS     (SET_PTR_WIDTH_IN_BITS),
        .WRITE_MASK_LEN            (WRITE_MASK_LEN)
    ) u_ram (
        .clk_in             (clk_in),
        .access_en_in       (ram_access_en),
        .write_en_in        (ram_write_en),
        .access_set_addr_in (ram_addr),
        .write_entry_in     (ram_wdata),
        .read_entry_out     (ram_rdata)
    );

    // Next state and RAM drive. Requests pass straight through to the RAM
    // in IDLE so back-to-back writes sustain one per cycle.
    always_comb begin
        state_next      = state;
        ram_access_en   = 1'b0;
        ram_write_en    = '0;
        ram_addr        = request_addr_in;
        ram_wdata       = request_data_in;
        request_ack_out = (state == IDLE);

        case (state)
            INIT: begin
                ram_access_en = 1'b1;
                ram_write_en  = '1;
                ram_addr      = init_cnt;
                ram_wdata     = '0;
                if (init_cnt == LAST_SET) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (request_valid_in) begin
                    ram_access_en = 1'b1;
                    if (request_write_in) begin
                        ram_write_en = request_write_mask_in;
                    end else begin
                        state_next = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                state_next = RESP;
            end
            RESP: begin
                if (response_ack_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state              <= INIT;
            init_cnt           <= '0;
            init_done_out      <= 1'b0;
            response_valid_out <= 1'b0;
            response_data_out  <= '0;
        end else begin
            state <= state_next;

            // Counter parks on the last set; leaving INIT is what ends the sweep.
            if (state == INIT) begin
                if (init_cnt == LAST_SET) begin
                    init_done_out <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end

            // RAM output is valid during READ_WAIT; capture it so the
            // response stays stable however long the consumer stalls.
            if (state == READ_WAIT) begin
                response_valid_out <= 1'b1;
                response_data_out  <= ram_rdata;
            end

            if (state == RESP && response_ack_in) begin
                response_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blockram_access_ctrl.sv
module tb_blockram_access_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        init_done_out;
    logic        request_valid_in = 1'b0;
    logic        request_ack_out;
    logic        request_write_in = 1'b0;
    logic [7:0]  request_write_mask_in = '0;
    logic [5:0]  request_addr_in = '0;
    logic [63:0] request_data_in = '0;
    logic        response_valid_out;
    logic [63:0] response_data_out;
    logic        response_ack_in = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    blockram_access_ctrl dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .init_done_out         (init_done_out),
        .request_valid_in      (request_valid_in),
        .request_ack_out       (request_ack_out),
        .request_write_in      (request_write_in),
        .request_write_mask_in (request_write_mask_in),
        .request_addr_in       (request_addr_in),
        .request_data_in       (request_data_in),
        .response_valid_out    (response_valid_out),
        .response_data_out     (response_data_out),
        .response_ack_in       (response_ack_in)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  mask;
        logic [5:0]  addr;
        logic [63:0] data;
        logic [63:0] expect_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Hold reset 5 cycles, release, and count edges until init completes.
    task automatic reset_and_init();
        int cnt;
        bit seen_ack;
        reset_in = 1'b0;
        request_valid_in = 1'b0;
        response_ack_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        check("rst_init_done", 64'(init_done_out), 64'd0);
        check("rst_req_ack", 64'(request_ack_out), 64'd0);
        check("rst_resp_vld", 64'(response_valid_out), 64'd0);
        check("rst_resp_dat", response_data_out, 64'd0);
        @(negedge clk_in);
        reset_in = 1'b1;
        cnt = 0;
        seen_ack = 1'b0;
        do begin
            @(posedge clk_in);
            #1;
            cnt++;
            if (request_ack_out && !init_done_out) seen_ack = 1'b1;
        end while (!init_done_out && cnt < 200);
        check("init_cycles", 64'(cnt), 64'd64);
        check("ack_during_init", 64'(seen_ack), 64'd0);
        check("ack_after_init", 64'(request_ack_out), 64'd1);
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [63:0] data, input logic [7:0] mask);
        @(negedge clk_in);
        check("wr_ack", 64'(request_ack_out), 64'd1);
        request_valid_in = 1'b1;
        request_write_in = 1'b1;
        request_write_mask_in = mask;
        request_addr_in = addr;
        request_data_in = data;
        @(posedge clk_in);
        #1;
        request_valid_in = 1'b0;
        request_write_in = 1'b0;
    endtask

    // Issue a read and follow it into RESP, checking the two-edge latency.
    task automatic read_issue(input logic [5:0] addr);
        @(negedge clk_in);
        request_valid_in = 1'b1;
        request_write_in = 1'b0;
        request_addr_in = addr;
        @(posedge clk_in);
        #1;
        request_valid_in = 1'b0;
        check("rd_vld_after_1", 64'(response_valid_out), 64'd0);
        check("rd_ack_in_wait", 64'(request_ack_out), 64'd0);
        @(posedge clk_in);
        #1;
        check("rd_vld_after_2", 64'(response_valid_out), 64'd1);
    endtask

    task automatic read_finish(input int hold, input logic [63:0] exp);
        logic [63:0] first;
        first = response_data_out;
        check("rd_data", first, exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_in);
            #1;
            check("hold_vld", 64'(response_valid_out), 64'd1);
            check("hold_dat", response_data_out, first);
            check("hold_req_ack", 64'(request_ack_out), 64'd0);
        end
        response_ack_in = 1'b1;
        @(posedge clk_in);
        #1;
        response_ack_in = 1'b0;
        check("resp_vld_clear", 64'(response_valid_out), 64'd0);
        check("resp_data_kept", response_data_out, first);
        check("back_to_idle", 64'(request_ack_out), 64'd1);
    endtask

    initial begin
        vecs.push_back('{1'b1, 8'hFF, 6'd63, 64'hFFFFFFFF_00000000, 64'h0});
        vecs.push_back('{1'b0, 8'h00, 6'd63, 64'h0, 64'hFFFFFFFF_00000000});
        vecs.push_back('{1'b1, 8'hFF, 6'd62, 64'h0, 64'h0});
        vecs.push_back('{1'b1, 8'hCC, 6'd62, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        vecs.push_back('{1'b0, 8'h00, 6'd62, 64'h0, 64'hFFFF0000_FFFF0000});
        vecs.push_back('{1'b1, 8'hFF, 6'd10, 64'h0123_4567_89AB_CDEF, 64'h0});
        vecs.push_back('{1'b1, 8'h00, 6'd10, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0});
        vecs.push_back('{1'b0, 8'h00, 6'd10, 64'h0, 64'h0123_4567_89AB_CDEF});
        vecs.push_back('{1'b1, 8'h01, 6'd0, 64'h0000_0000_0000_00AA, 64'h0});
        vecs.push_back('{1'b0, 8'h00, 6'd0, 64'h0, 64'h0000_0000_0000_00AA});

        reset_and_init();

        // Freshly cleared set must read as zero, not X.
        read_issue(6'd63);
        read_finish(0, 64'h0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
            end else begin
                read_issue(vecs[i].addr);
                read_finish(0, vecs[i].expect_dat);
            end
        end

        // Stalled consumer: response held 10 cycles, then a fresh read.
        read_issue(6'd62);
        read_finish(10, 64'hFFFF0000_FFFF0000);
        read_issue(6'd63);
        read_finish(0, 64'hFFFFFFFF_00000000);

        // Back-to-back writes to sets 0..3, then a write directly followed by a read.
        @(negedge clk_in);
        request_valid_in = 1'b1;
        request_write_in = 1'b1;
        request_write_mask_in = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            request_addr_in = 6'(i);
            request_data_in = 64'(i);
            @(negedge clk_in);
            check("b2b_ack", 64'(request_ack_out), 64'd1);
        end
        request_addr_in = 6'd5;
        request_data_in = 64'hA5A5_5A5A_0F0F_F0F0;
        @(negedge clk_in);
        request_write_in = 1'b0;
        @(posedge clk_in);
        #1;
        request_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("wr_rd_vld", 64'(response_valid_out), 64'd1);
        read_finish(0, 64'hA5A5_5A5A_0F0F_F0F0);

        for (int i = 0; i < 4; i++) begin
            read_issue(6'(i));
            read_finish(0, 64'(i));
        end

        // Reset while a response is pending drops it asynchronously.
        do_write(6'd63, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        read_issue(6'd3);
        #2;
        reset_in = 1'b0;
        #1;
        check("async_rst_vld", 64'(response_valid_out), 64'd0);
        check("async_rst_dat", response_data_out, 64'd0);
        reset_and_init();
        check("no_stale_resp", 64'(response_valid_out), 64'd0);
        read_issue(6'd63);
        read_finish(0, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
